// File: rtl/hdma_vram_mover.sv
// Three-stage HDMA/GDMA data mover: issue a source read, capture the byte, write it into VRAM.
// Holds the CPU stalled until the final VRAM write strobe has retired.
`timescale 1ns/1ps
module hdma_vram_mover #(
   parameter int DROP_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ce,
   input  logic              hdma_rd,
   input  logic              hdma_active,
   input  logic [15:0]       hdma_source_addr,
   input  logic [15:0]       hdma_target_addr,
   input  logic              vram_bank,
   input  logic [1:0]        lcd_mode,
   output logic [15:0]       src_addr,
   output logic              src_rd,
   input  logic [7:0]        src_din,
   output logic [13:0]       vram_addr,
   output logic              vram_we,
   output logic [7:0]        vram_dout,
   output logic              cpu_stall,
   output logic [15:0]       byte_count,
   output logic [DROP_W-1:0] drop_count
);

   localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};
   localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

   logic        tgt_valid_r;
   logic [15:0] last_tgt_r;
   logic [13:0] tgt_q_r;
   logic [13:0] wr_tgt_r;
   logic [7:0]  data_q_r;
   logic        wr_pend_r;
   logic        issue_s;

   // Echo RAM (E000-FFFF) aliases onto external RAM at A000-BFFF.
   function automatic logic [15:0] map_src(input logic [15:0] a);
      logic [15:0] m;
      if (a[15:13] == 3'b111) begin
         m = {3'b101, a[12:0]};
      end else begin
         m = a;
      end
      return m;
   endfunction

   // A read is issued once per distinct target while hdma_rd stays high.
   always_comb begin
      issue_s = hdma_rd && (!tgt_valid_r || (hdma_target_addr != last_tgt_r));
   end

   // Stall covers the engine's ownership plus every byte still in the pipeline.
   always_comb begin
      cpu_stall = hdma_active | src_rd | wr_pend_r | vram_we;
   end

   // Pipeline stages A (issue), B (capture) and C (write); all advance only on ce.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         src_addr    <= 16'h0000;
         src_rd      <= 1'b0;
         tgt_q_r     <= 14'h0000;
         last_tgt_r  <= 16'h0000;
         tgt_valid_r <= 1'b0;
         data_q_r    <= 8'h00;
         wr_tgt_r    <= 14'h0000;
         wr_pend_r   <= 1'b0;
         vram_addr   <= 14'h0000;
         vram_we     <= 1'b0;
         vram_dout   <= 8'h00;
         byte_count  <= 16'h0000;
         drop_count  <= {DROP_W{1'b0}};
      end else if (ce) begin
         src_rd <= issue_s;
         if (issue_s) begin
            src_addr    <= map_src(hdma_source_addr);
            tgt_q_r     <= {vram_bank, hdma_target_addr[12:0]};
            last_tgt_r  <= hdma_target_addr;
            tgt_valid_r <= 1'b1;
         end else if (!hdma_rd) begin
            tgt_valid_r <= 1'b0;
         end

         // Source data is valid one ce after the strobe; a new capture overrides the clear.
         if (src_rd) begin
            data_q_r  <= src_din;
            wr_tgt_r  <= tgt_q_r;
            wr_pend_r <= 1'b1;
         end else begin
            wr_pend_r <= 1'b0;
         end

         // Mode 3 locks VRAM, so the pending byte is discarded rather than delayed.
         if (wr_pend_r && (lcd_mode != 2'd3)) begin
            vram_we    <= 1'b1;
            vram_addr  <= wr_tgt_r;
            vram_dout  <= data_q_r;
            byte_count <= byte_count + 16'd1;
         end else begin
            vram_we <= 1'b0;
            if (wr_pend_r && (drop_count != DROP_MAX)) begin
               drop_count <= drop_count + DROP_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_hdma_vram_mover.sv
// Scoreboard bench for hdma_vram_mover: expected VRAM writes are queued at issue and popped per strobe.
`timescale 1ns/1ps
module tb_hdma_vram_mover;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ce = 1'b0;
   logic        hdma_rd = 1'b0;
   logic        hdma_active = 1'b0;
   logic [15:0] hdma_source_addr = 16'h0000;
   logic [15:0] hdma_target_addr = 16'h8000;
   logic        vram_bank = 1'b0;
   logic [1:0]  lcd_mode = 2'd1;
   logic [15:0] src_addr;
   logic        src_rd;
   logic [7:0]  src_din;
   logic [13:0] vram_addr;
   logic        vram_we;
   logic [7:0]  vram_dout;
   logic        cpu_stall;
   logic [15:0] byte_count;
   logic [7:0]  drop_count;

   int errors = 0;
   int checks = 0;
   int rd_count = 0;
   int we_count = 0;
   int exp_drop = 0;
   logic [15:0] exp_bytes = 16'h0000;
   logic [21:0] exp_q[$];

   hdma_vram_mover #(.DROP_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .ce(ce), .hdma_rd(hdma_rd), .hdma_active(hdma_active),
      .hdma_source_addr(hdma_source_addr), .hdma_target_addr(hdma_target_addr),
      .vram_bank(vram_bank), .lcd_mode(lcd_mode), .src_addr(src_addr), .src_rd(src_rd),
      .src_din(src_din), .vram_addr(vram_addr), .vram_we(vram_we), .vram_dout(vram_dout),
      .cpu_stall(cpu_stall), .byte_count(byte_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_f(input logic [15:0] a);
      return a[7:0] ^ {a[14:8], a[15]} ^ 8'h5A;
   endfunction

   function automatic logic [15:0] echo_f(input logic [15:0] a);
      logic [15:0] m;
      m = a;
      if (a >= 16'hE000) m = a - 16'h4000;
      return m;
   endfunction

   assign src_din = mem_f(src_addr);

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // One ce pulse followed by one idle clock; the write monitor runs right after the ce edge.
   task automatic ce_step();
      logic [21:0] e;
      @(negedge clk) ce = 1'b1;
      @(posedge clk);
      #1 ce = 1'b0;
      if (src_rd) rd_count++;
      if (vram_we) begin
         we_count++;
         if (exp_q.size() == 0) begin
            check_eq("we_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_eq("we_addr_data", {10'd0, vram_addr, vram_dout}, {10'd0, e});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive_byte(input logic [15:0] src, input logic [15:0] tgt, input bit wr);
      hdma_source_addr = src;
      hdma_target_addr = tgt;
      hdma_rd = 1'b1;
      if (wr) begin
         exp_q.push_back({vram_bank, tgt[12:0], mem_f(echo_f(src))});
         exp_bytes = exp_bytes + 16'd1;
      end
   endtask

   // Back-to-back bytes with ce held high every clock; only the counters are checked afterwards.
   task automatic bulk(input int n, input logic [1:0] mode);
      lcd_mode = mode;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ce = 1'b1;
         hdma_rd = 1'b1;
         hdma_source_addr = 16'(i);
         hdma_target_addr = 16'h8000 | 16'(i % 8192);
      end
      @(negedge clk) hdma_rd = 1'b0;
      repeat (4) @(negedge clk);
      ce = 1'b0;
      lcd_mode = 2'd1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      exp_q.delete();
      exp_bytes = 16'h0000;
      exp_drop = 0;
      #3 reset_n = 1'b1;
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int rd0;
      int we0;
      logic [15:0] b0;

      // Reset state
      #12;
      check_eq("rst_src_addr", 32'(src_addr), 32'd0);
      check_eq("rst_src_rd", 32'(src_rd), 32'd0);
      check_eq("rst_vram_we", 32'(vram_we), 32'd0);
      check_eq("rst_byte_count", 32'(byte_count), 32'd0);
      check_eq("rst_stall", 32'(cpu_stall), 32'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // GDMA, 32 bytes at 2 ce per byte
      hdma_active = 1'b1;
      vram_bank = 1'b1;
      we0 = we_count;
      for (int i = 0; i < 32; i++) begin
         drive_byte(16'h2040 + 16'(i), 16'h8200 + 16'(i), 1'b1);
         ce_step();
         ce_step();
      end
      hdma_rd = 1'b0;
      hdma_active = 1'b0;
      check_eq("gdma_stall_tail0", 32'(cpu_stall), 32'd1);
      ce_step();
      check_eq("gdma_stall_tail1", 32'(cpu_stall), 32'd1);
      ce_step();
      check_eq("gdma_stall_tail2", 32'(cpu_stall), 32'd0);
      check_eq("gdma_we_count", 32'(we_count - we0), 32'd32);
      check_eq("gdma_byte_count", 32'(byte_count), 32'(exp_bytes));
      check_eq("gdma_q_empty", 32'(exp_q.size()), 32'd0);

      // Echo mapping
      vram_bank = 1'b0;
      drive_byte(16'hE123, 16'h8300, 1'b1);
      ce_step();
      check_eq("echo_src_rd", 32'(src_rd), 32'd1);
      check_eq("echo_e123", 32'(src_addr), 32'h0000A123);
      drive_byte(16'hD123, 16'h8301, 1'b1);
      ce_step();
      check_eq("echo_d123", 32'(src_addr), 32'h0000D123);
      hdma_rd = 1'b0;
      repeat (3) ce_step();
      check_eq("echo_q_empty", 32'(exp_q.size()), 32'd0);

      // Dedup: constant target read once, re-read after hdma_rd drops
      rd0 = rd_count;
      we0 = we_count;
      drive_byte(16'h1000, 16'h8000, 1'b1);
      repeat (6) ce_step();
      check_eq("dedup_rd1", 32'(rd_count - rd0), 32'd1);
      check_eq("dedup_we1", 32'(we_count - we0), 32'd1);
      hdma_rd = 1'b0;
      ce_step();
      drive_byte(16'h1000, 16'h8000, 1'b1);
      repeat (4) ce_step();
      hdma_rd = 1'b0;
      ce_step();
      check_eq("dedup_rd2", 32'(rd_count - rd0), 32'd2);
      check_eq("dedup_we2", 32'(we_count - we0), 32'd2);

      // Mode-3 drop on byte 5's write ce
      b0 = byte_count;
      we0 = we_count;
      for (int i = 0; i < 16; i++) begin
         drive_byte(16'h3000 + 16'(i), 16'h8500 + 16'(i), i != 4);
         if (i == 5) lcd_mode = 2'd3;
         ce_step();
         lcd_mode = 2'd1;
         ce_step();
      end
      exp_drop = exp_drop + 1;
      hdma_rd = 1'b0;
      repeat (3) ce_step();
      check_eq("m3_we_count", 32'(we_count - we0), 32'd15);
      check_eq("m3_byte_delta", 32'(byte_count - b0), 32'd15);
      check_eq("m3_drop_count", 32'(drop_count), 32'(exp_drop));
      check_eq("m3_q_empty", 32'(exp_q.size()), 32'd0);

      // Async reset right after a capture
      drive_byte(16'h4000, 16'h8400, 1'b1);
      ce_step();
      ce_step();
      hdma_rd = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check_eq("arst_src_addr", 32'(src_addr), 32'd0);
      check_eq("arst_src_rd", 32'(src_rd), 32'd0);
      check_eq("arst_vram_addr", 32'(vram_addr), 32'd0);
      check_eq("arst_vram_we", 32'(vram_we), 32'd0);
      check_eq("arst_vram_dout", 32'(vram_dout), 32'd0);
      check_eq("arst_byte_count", 32'(byte_count), 32'd0);
      check_eq("arst_drop_count", 32'(drop_count), 32'd0);
      check_eq("arst_stall", 32'(cpu_stall), 32'd0);
      exp_q.delete();
      exp_bytes = 16'h0000;
      exp_drop = 0;
      #3 reset_n = 1'b1;
      we0 = we_count;
      repeat (4) ce_step();
      check_eq("arst_no_we", 32'(we_count - we0), 32'd0);
      drive_byte(16'h4001, 16'h8401, 1'b1);
      ce_step();
      hdma_rd = 1'b0;
      repeat (3) ce_step();
      check_eq("arst_new_we", 32'(we_count - we0), 32'd1);
      check_eq("arst_new_bytes", 32'(byte_count), 32'(exp_bytes));

      // Drop counter saturation
      b0 = byte_count;
      bulk(260, 2'd3);
      exp_drop = (exp_drop + 260 > 255) ? 255 : exp_drop + 260;
      check_eq("sat_drop_count", 32'(drop_count), 32'(exp_drop));
      check_eq("sat_byte_hold", 32'(byte_count), 32'(b0));

      // Byte counter wrap
      do_reset();
      @(posedge clk);
      #1;
      bulk(65537, 2'd1);
      exp_bytes = exp_bytes + 16'(65537);
      check_eq("wrap_byte_count", 32'(byte_count), 32'(exp_bytes));
      check_eq("wrap_drop_zero", 32'(drop_count), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
